// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if -- bundle of the pipeline request/response handshake and
// the memory read/write port used by mem_access_ctrl.
//
// Parameters: ADDR_WIDTH (byte address width), DATA_WIDTH (data/bus width).
// Modports:
//   slave  -- the controller: takes requests, returns responses, drives memory.
//   master -- the pipeline plus memory side (the testbench).
// Signals:
//   iReq_valid/oReq_ready, iReq_wen, iReq_addr, iReq_wdata, iReq_size,
//   iReq_signed                     request channel
//   oResp_valid/iResp_ready, oResp_rdata, oResp_err     response channel
//   pMem_bRdEn, pMem_bRdAddrB, pMem_bRdDataB            memory read port
//   pMem_bWrEn, pMem_bWrAddr, pMem_bWrData,
//   pMem_bWrMask_0..pMem_bWrMask_3                      memory write port
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  iReq_valid;
    logic                  oReq_ready;
    logic                  iReq_wen;
    logic [ADDR_WIDTH-1:0] iReq_addr;
    logic [DATA_WIDTH-1:0] iReq_wdata;
    logic [1:0]            iReq_size;
    logic                  iReq_signed;

    logic                  oResp_valid;
    logic                  iResp_ready;
    logic [DATA_WIDTH-1:0] oResp_rdata;
    logic                  oResp_err;

    logic                  pMem_bRdEn;
    logic [ADDR_WIDTH-1:0] pMem_bRdAddrB;
    logic [DATA_WIDTH-1:0] pMem_bRdDataB;

    logic                  pMem_bWrEn;
    logic [ADDR_WIDTH-1:0] pMem_bWrAddr;
    logic [DATA_WIDTH-1:0] pMem_bWrData;
    logic                  pMem_bWrMask_0;
    logic                  pMem_bWrMask_1;
    logic                  pMem_bWrMask_2;
    logic                  pMem_bWrMask_3;

    modport slave (
        input  iReq_valid, iReq_wen, iReq_addr, iReq_wdata, iReq_size, iReq_signed,
        input  iResp_ready, pMem_bRdDataB,
        output oReq_ready, oResp_valid, oResp_rdata, oResp_err,
        output pMem_bRdEn, pMem_bRdAddrB,
        output pMem_bWrEn, pMem_bWrAddr, pMem_bWrData,
        output pMem_bWrMask_0, pMem_bWrMask_1, pMem_bWrMask_2, pMem_bWrMask_3
    );

    modport master (
        output iReq_valid, iReq_wen, iReq_addr, iReq_wdata, iReq_size, iReq_signed,
        output iResp_ready, pMem_bRdDataB,
        input  oReq_ready, oResp_valid, oResp_rdata, oResp_err,
        input  pMem_bRdEn, pMem_bRdAddrB,
        input  pMem_bWrEn, pMem_bWrAddr, pMem_bWrData,
        input  pMem_bWrMask_0, pMem_bWrMask_1, pMem_bWrMask_2, pMem_bWrMask_3
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- single-outstanding load/store controller between a CPU
// pipeline and a synchronous memory port. One access per three cycles:
// IDLE (accept) -> ACCESS (one memory cycle) -> RESP (hold until consumed).
//
// Ports:
//   clock  -- sole clock, rising edge
//   reset  -- synchronous active-high reset
//   bus    -- mem_access_ctrl_if.slave: request, response and memory ports
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to flag misaligned half/word
// accesses with oResp_err and skip the memory cycle for them. Without it,
// oResp_err is always 0 and every access goes to memory.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    mem_access_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q;
    logic                  ready_q;
    logic                  wen_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  miss_q;

    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [3:0]            mask_q;      // {mask_0, mask_1, mask_2, mask_3}

    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  misalign_d;
    logic [3:0]            mask_d;
    logic [DATA_WIDTH-1:0] ld_data_d;

    // Alignment of the incoming request, evaluated at the accept edge.
`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign_d = 1'b0;
        case (bus.iReq_size)
            2'd0:    misalign_d = 1'b0;
            2'd1:    misalign_d = bus.iReq_addr[0];
            default: misalign_d = (bus.iReq_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign_d = 1'b0;
`endif

    always_comb begin
        mask_d = 4'b1111;
        case (bus.iReq_size)
            2'd0:    mask_d = 4'b0001;
            2'd1:    mask_d = 4'b0011;
            default: mask_d = 4'b1111;
        endcase
    end

    // Load extension on the data the memory returns during ACCESS.
    always_comb begin
        ld_data_d = bus.pMem_bRdDataB;
        case (size_q)
            2'd0:    ld_data_d = {{(DATA_WIDTH-8){signed_q & bus.pMem_bRdDataB[7]}},
                                  bus.pMem_bRdDataB[7:0]};
            2'd1:    ld_data_d = {{(DATA_WIDTH-16){signed_q & bus.pMem_bRdDataB[15]}},
                                  bus.pMem_bRdDataB[15:0]};
            default: ld_data_d = bus.pMem_bRdDataB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            wen_q        <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            miss_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            mask_q       <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iReq_valid) begin
                        state_q  <= ACCESS;
                        ready_q  <= 1'b0;
                        wen_q    <= bus.iReq_wen;
                        size_q   <= bus.iReq_size;
                        signed_q <= bus.iReq_signed;
                        miss_q   <= misalign_d;
                        // Memory-port registers are loaded here so they are
                        // live exactly during the ACCESS cycle.
                        if (!misalign_d) begin
                            if (bus.iReq_wen) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= bus.iReq_addr;
                                wr_data_q <= bus.iReq_wdata;
                                mask_q    <= mask_d;
                            end else begin
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= bus.iReq_addr;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    rd_en_q      <= 1'b0;
                    rd_addr_q    <= '0;
                    wr_en_q      <= 1'b0;
                    wr_addr_q    <= '0;
                    wr_data_q    <= '0;
                    mask_q       <= '0;
                    resp_valid_q <= 1'b1;
                    err_q        <= miss_q;
                    rdata_q      <= (miss_q || wen_q) ? '0 : ld_data_d;
                end
                RESP: begin
                    if (bus.iResp_ready) begin
                        state_q      <= IDLE;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b0;
                        rdata_q      <= '0;
                        err_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.oReq_ready  = ready_q;
    assign bus.oResp_valid = resp_valid_q;
    assign bus.oResp_rdata = rdata_q;
    assign bus.oResp_err   = err_q;

    // Memory port is forced quiet while reset is high, so a reset landing in
    // ACCESS never lets the write (or read) through on that cycle.
    assign bus.pMem_bRdEn     = rd_en_q & ~reset;
    assign bus.pMem_bRdAddrB  = reset ? '0 : rd_addr_q;
    assign bus.pMem_bWrEn     = wr_en_q & ~reset;
    assign bus.pMem_bWrAddr   = reset ? '0 : wr_addr_q;
    assign bus.pMem_bWrData   = reset ? '0 : wr_data_q;
    assign bus.pMem_bWrMask_0 = mask_q[3] & ~reset;
    assign bus.pMem_bWrMask_1 = mask_q[2] & ~reset;
    assign bus.pMem_bWrMask_2 = mask_q[1] & ~reset;
    assign bus.pMem_bWrMask_3 = mask_q[0] & ~reset;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mem_access_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] mask_now();
        return {bus.pMem_bWrMask_0, bus.pMem_bWrMask_1, bus.pMem_bWrMask_2, bus.pMem_bWrMask_3};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents a request for one accept edge; returns #1 into the ACCESS cycle.
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn);
        bus.iReq_valid  = 1'b1;
        bus.iReq_wen    = wen;
        bus.iReq_addr   = addr;
        bus.iReq_wdata  = wdata;
        bus.iReq_size   = size;
        bus.iReq_signed = sgn;
        step();
        bus.iReq_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.oReq_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.oReq_ready); end
        checks++; if (bus.oResp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.oResp_valid); end
        checks++; if (bus.oResp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.oResp_rdata); end
        checks++; if (bus.oResp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.oResp_err); end
        checks++; if ({bus.pMem_bRdEn, bus.pMem_bWrEn, mask_now()} !== 6'b0) begin errors++; $display("FAIL rst_mem got %b exp 0", {bus.pMem_bRdEn, bus.pMem_bWrEn, mask_now()}); end
        checks++; if ({bus.pMem_bRdAddrB, bus.pMem_bWrAddr, bus.pMem_bWrData} !== 96'h0) begin errors++; $display("FAIL rst_bus got %h exp 0", {bus.pMem_bRdAddrB, bus.pMem_bWrAddr, bus.pMem_bWrData}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_word_load();
        bus.iResp_ready   = 1'b1;
        bus.pMem_bRdDataB = 32'hDEADBEEF;
        issue(1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0);
        checks++; if (bus.pMem_bRdEn !== 1'b1) begin errors++; $display("FAIL wl_rden got %b exp 1", bus.pMem_bRdEn); end
        checks++; if (bus.pMem_bRdAddrB !== 32'h80000004) begin errors++; $display("FAIL wl_addr got %h exp 80000004", bus.pMem_bRdAddrB); end
        checks++; if (bus.pMem_bWrEn !== 1'b0) begin errors++; $display("FAIL wl_wren got %b exp 0", bus.pMem_bWrEn); end
        checks++; if (bus.oReq_ready !== 1'b0) begin errors++; $display("FAIL wl_ready_acc got %b exp 0", bus.oReq_ready); end
        step();
        checks++; if (bus.pMem_bRdEn !== 1'b0 || bus.pMem_bRdAddrB !== 32'h0) begin errors++; $display("FAIL wl_rd_off got %b/%h exp 0/0", bus.pMem_bRdEn, bus.pMem_bRdAddrB); end
        checks++; if (bus.oResp_valid !== 1'b1) begin errors++; $display("FAIL wl_valid got %b exp 1", bus.oResp_valid); end
        checks++; if (bus.oResp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_rdata got %h exp deadbeef", bus.oResp_rdata); end
        checks++; if (bus.oResp_err !== 1'b0) begin errors++; $display("FAIL wl_err got %b exp 0", bus.oResp_err); end
        step();
        checks++; if (bus.oResp_valid !== 1'b0 || bus.oReq_ready !== 1'b1) begin errors++; $display("FAIL wl_done got v%b r%b exp v0 r1", bus.oResp_valid, bus.oReq_ready); end
    endtask

    task automatic test_byte_load();
        bus.iResp_ready   = 1'b1;
        bus.pMem_bRdDataB = 32'h00000080;
        issue(1'b0, 32'h80000001, 32'h0, 2'd0, 1'b1);
        step();
        checks++; if (bus.oResp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL bl_signed got %h exp ffffff80", bus.oResp_rdata); end
        step();
        issue(1'b0, 32'h80000001, 32'h0, 2'd0, 1'b0);
        step();
        checks++; if (bus.oResp_rdata !== 32'h00000080) begin errors++; $display("FAIL bl_unsigned got %h exp 00000080", bus.oResp_rdata); end
        step();
        // Upper bytes of the memory word must be discarded on a byte load.
        bus.pMem_bRdDataB = 32'h1234567F;
        issue(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1);
        step();
        checks++; if (bus.oResp_rdata !== 32'h0000007F) begin errors++; $display("FAIL bl_pos got %h exp 0000007f", bus.oResp_rdata); end
        step();
    endtask

    task automatic test_half_store();
        bus.iResp_ready = 1'b1;
        issue(1'b1, 32'h80000010, 32'h1234ABCD, 2'd1, 1'b0);
        checks++; if (bus.pMem_bWrEn !== 1'b1) begin errors++; $display("FAIL hs_wren got %b exp 1", bus.pMem_bWrEn); end
        checks++; if (mask_now() !== 4'b0011) begin errors++; $display("FAIL hs_mask got %b exp 0011", mask_now()); end
        checks++; if (bus.pMem_bWrData !== 32'h1234ABCD) begin errors++; $display("FAIL hs_wdata got %h exp 1234abcd", bus.pMem_bWrData); end
        checks++; if (bus.pMem_bWrAddr !== 32'h80000010) begin errors++; $display("FAIL hs_waddr got %h exp 80000010", bus.pMem_bWrAddr); end
        checks++; if (bus.pMem_bRdEn !== 1'b0) begin errors++; $display("FAIL hs_rden got %b exp 0", bus.pMem_bRdEn); end
        step();
        checks++; if (bus.pMem_bWrEn !== 1'b0 || mask_now() !== 4'b0000 || bus.pMem_bWrData !== 32'h0) begin errors++; $display("FAIL hs_off got %b/%b/%h exp 0/0000/0", bus.pMem_bWrEn, mask_now(), bus.pMem_bWrData); end
        checks++; if (bus.oResp_valid !== 1'b1 || bus.oResp_rdata !== 32'h0) begin errors++; $display("FAIL hs_resp got v%b d%h exp v1 d0", bus.oResp_valid, bus.oResp_rdata); end
        step();
        // Byte and word store masks.
        issue(1'b1, 32'h80000020, 32'h000000AA, 2'd0, 1'b0);
        checks++; if (mask_now() !== 4'b0001) begin errors++; $display("FAIL bs_mask got %b exp 0001", mask_now()); end
        step();
        step();
        issue(1'b1, 32'h80000024, 32'hCAFEF00D, 2'd3, 1'b0);
        checks++; if (mask_now() !== 4'b1111) begin errors++; $display("FAIL ws_mask got %b exp 1111", mask_now()); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        bus.iResp_ready   = 1'b0;
        bus.pMem_bRdDataB = 32'h5555F00D;
        issue(1'b0, 32'h80000040, 32'h0, 2'd1, 1'b1);
        // A second request is held pending throughout RESP.
        bus.iReq_valid = 1'b1;
        bus.iReq_addr  = 32'h80000044;
        bus.iReq_size  = 2'd2;
        bus.iReq_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.oResp_valid !== 1'b1 || bus.oResp_rdata !== 32'hFFFFF00D) begin errors++; $display("FAIL bp_hold%0d got v%b d%h exp v1 dfffff00d", i, bus.oResp_valid, bus.oResp_rdata); end
            checks++; if (bus.oReq_ready !== 1'b0 || bus.pMem_bRdEn !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got r%b e%b exp r0 e0", i, bus.oReq_ready, bus.pMem_bRdEn); end
        end
        bus.iResp_ready = 1'b1;
        step();
        checks++; if (bus.oResp_valid !== 1'b0 || bus.oReq_ready !== 1'b1 || bus.pMem_bRdEn !== 1'b0) begin errors++; $display("FAIL bp_idle got v%b r%b e%b exp v0 r1 e0", bus.oResp_valid, bus.oReq_ready, bus.pMem_bRdEn); end
        step();
        bus.iReq_valid = 1'b0;
        checks++; if (bus.pMem_bRdEn !== 1'b1 || bus.pMem_bRdAddrB !== 32'h80000044) begin errors++; $display("FAIL bp_next got e%b a%h exp e1 a80000044", bus.pMem_bRdEn, bus.pMem_bRdAddrB); end
        step();
        checks++; if (bus.oResp_rdata !== 32'h5555F00D) begin errors++; $display("FAIL bp_next_data got %h exp 5555f00d", bus.oResp_rdata); end
        step();
    endtask

    task automatic test_reset_in_access();
        bus.iResp_ready = 1'b1;
        issue(1'b1, 32'h80000030, 32'h87654321, 2'd2, 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (bus.pMem_bWrEn !== 1'b0) begin errors++; $display("FAIL ra_wren_cyc got %b exp 0", bus.pMem_bWrEn); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus.pMem_bWrEn !== 1'b0 || mask_now() !== 4'b0000) begin errors++; $display("FAIL ra_wren_next got %b/%b exp 0/0000", bus.pMem_bWrEn, mask_now()); end
        checks++; if (bus.oReq_ready !== 1'b1) begin errors++; $display("FAIL ra_ready got %b exp 1", bus.oReq_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.oResp_valid !== 1'b0) begin errors++; $display("FAIL ra_noresp%0d got %b exp 0", i, bus.oResp_valid); end
            step();
        end
    endtask

    task automatic test_misalign();
        bus.iResp_ready   = 1'b1;
        bus.pMem_bRdDataB = 32'h11112222;
        issue(1'b0, 32'h80000002, 32'h0, 2'd2, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
        checks++; if (bus.pMem_bRdEn !== 1'b0) begin errors++; $display("FAIL ma_rden got %b exp 0", bus.pMem_bRdEn); end
        step();
        checks++; if (bus.oResp_valid !== 1'b1 || bus.oResp_err !== 1'b1 || bus.oResp_rdata !== 32'h0) begin errors++; $display("FAIL ma_resp got v%b e%b d%h exp v1 e1 d0", bus.oResp_valid, bus.oResp_err, bus.oResp_rdata); end
`else
        checks++; if (bus.pMem_bRdEn !== 1'b1 || bus.pMem_bRdAddrB !== 32'h80000002) begin errors++; $display("FAIL ma_rden got e%b a%h exp e1 a80000002", bus.pMem_bRdEn, bus.pMem_bRdAddrB); end
        step();
        checks++; if (bus.oResp_valid !== 1'b1 || bus.oResp_err !== 1'b0 || bus.oResp_rdata !== 32'h11112222) begin errors++; $display("FAIL ma_resp got v%b e%b d%h exp v1 e0 d11112222", bus.oResp_valid, bus.oResp_err, bus.oResp_rdata); end
`endif
        step();
        checks++; if (bus.oResp_err !== 1'b0) begin errors++; $display("FAIL ma_err_clr got %b exp 0", bus.oResp_err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset             = 1'b1;
        bus.iReq_valid    = 1'b0;
        bus.iReq_wen      = 1'b0;
        bus.iReq_addr     = '0;
        bus.iReq_wdata    = '0;
        bus.iReq_size     = '0;
        bus.iReq_signed   = 1'b0;
        bus.iResp_ready   = 1'b1;
        bus.pMem_bRdDataB = '0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_back_to_back();
        test_reset_in_access();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameters ADDR_WIDTH (default 32, byte-address width) and DATA_WIDTH (default 32, data and bus width).
REQ-002 SHALL have port clock, input, 1, sole clock; all logic on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port iReq_valid, input, 1, pipeline access request present.
REQ-005 SHALL have port oReq_ready, output, 1, controller can accept a request.
REQ-006 SHALL have port iReq_wen, input, 1, 1=store, 0=load.
REQ-007 SHALL have port iReq_addr, input, ADDR_WIDTH, byte address.
REQ-008 SHALL have port iReq_wdata, input, DATA_WIDTH, store data, LSB-justified.
REQ-009 SHALL have port iReq_size, input, 2, access size: 0=byte, 1=half, 2/3=word.
REQ-010 SHALL have port iReq_signed, input, 1, load result sign-extended when 1.
REQ-011 SHALL have port oResp_valid, output, 1, response available.
REQ-012 SHALL have port iResp_ready, input, 1, pipeline accepts the response.
REQ-013 SHALL have port oResp_rdata, output, DATA_WIDTH, extended load data; 0 for stores.
REQ-014 SHALL have port oResp_err, output, 1, misaligned-access flag.
REQ-015 SHALL have ports pMem_bRdEn (output, 1), pMem_bRdAddrB (output, ADDR_WIDTH) and pMem_bRdDataB (input, DATA_WIDTH) for the memory data read port.
REQ-016 SHALL have ports pMem_bWrEn (output, 1), pMem_bWrAddr (output, ADDR_WIDTH), pMem_bWrData (output, DATA_WIDTH) and pMem_bWrMask_0..pMem_bWrMask_3 (output, 1 each) for the memory write port.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; oReq_ready = 1 only in IDLE.
REQ-018 SHALL register wen, addr, wdata, size and signed on the handshake (iReq_valid & oReq_ready) and move to ACCESS.
REQ-019 SHALL, in ACCESS for a load, drive pMem_bRdEn=1 and pMem_bRdAddrB=the registered address for exactly one cycle, then capture pMem_bRdDataB at the end of that cycle.
REQ-020 SHALL, in ACCESS for a store, drive pMem_bWrEn=1, pMem_bWrAddr=the address and pMem_bWrData=wdata (unshifted) for exactly one cycle.
REQ-021 SHALL encode the write mask as {pMem_bWrMask_0..3}: byte=0001, half=0011, word=1111; the mask SHALL be 0000 outside a store ACCESS cycle.
REQ-022 SHALL drive all pMem_* outputs to 0 in IDLE and RESP so that every access presents a fresh address and data change.
REQ-023 SHALL, for a load, form the result from captured data bits [7:0] (byte) or [15:0] (half), zero- or sign-extended per the signed flag; a word load SHALL pass all 32 bits through.
REQ-024 SHALL, in RESP, hold oResp_valid=1 with stable rdata and err until iResp_ready=1, then return to IDLE.
REQ-025 SHALL give a response two cycles after the accept edge when iResp_ready=1; throughput SHALL be one access per 3 cycles.
REQ-026 SHALL NOT accept a request in RESP in the same cycle the response is consumed; the next accept occurs in IDLE.

Reset
REQ-027 SHALL, on reset, set state=IDLE, oReq_ready=1, and oResp_valid, oResp_rdata, oResp_err and all pMem_* outputs to 0.
REQ-028 SHALL, when reset is asserted in ACCESS or RESP, abandon the access: no write enable on the reset cycle and no response afterwards.

Configuration
REQ-029 SHALL use macro MEM_MISALIGN_CHECK_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 skips memory (no pMem enables) and goes ACCESS -> RESP with oResp_err=1 and oResp_rdata=0.
REQ-030 SHALL, when MEM_MISALIGN_CHECK_EN is undefined, tie oResp_err to 0 and issue every access to memory unchanged.

Verification
REQ-031 SHALL verify a load of word 0x80000004 with memory returning 0xDEADBEEF: pMem_bRdEn=1 for one cycle with addr 0x80000004; oResp_rdata=0xDEADBEEF two cycles after accept.
REQ-032 SHALL verify a signed byte load with memory data 0x00000080: oResp_rdata=0xFFFFFF80; the unsigned version SHALL give 0x00000080.
REQ-033 SHALL verify a half store of 0x1234ABCD to 0x80000010: pMem_bWrEn=1 for one cycle, mask=0011, wdata=0x1234ABCD; response valid with rdata=0.
REQ-034 SHALL verify that holding iResp_ready=0 for 3 cycles keeps oResp_valid and rdata stable with oReq_ready=0, and that the next request is accepted only after the response is consumed.
REQ-035 SHALL verify that reset asserted in the ACCESS cycle of a store gives pMem_bWrEn=0 on the following cycle, no response, and oReq_ready=1.
REQ-036 SHALL verify, with MEM_MISALIGN_CHECK_EN defined, that a word load at 0x80000002 gives no pMem_bRdEn, oResp_err=1 and rdata=0; with the macro undefined, the memory read is issued and err=0.
